// File: rtl/btn_sw_conditioner.sv
`default_nettype none
// ============================================================================
// Module   : btn_sw_conditioner
// Brief    : 2-flop synchronizer and per-bit debouncer for push-buttons and
//            slide switches, with registered press/release/change pulses.
// Revision : 1.0 - initial release
// ============================================================================
module btn_sw_conditioner #(
    parameter int NB_BTN         = 4,
    parameter int NB_SW          = 4,
    parameter int NB_DEBOUNCE    = 20,
    parameter int DEBOUNCE_COUNT = 1000000
) (
    input  logic              clock,
    input  logic              reset,
    input  logic [NB_BTN-1:0] i_btn,
    input  logic [NB_SW-1:0]  i_sw,
    output logic [NB_BTN-1:0] o_btn_level,
    output logic [NB_BTN-1:0] o_btn_press,
    output logic [NB_BTN-1:0] o_btn_release,
    output logic [NB_SW-1:0]  o_sw_level,
    output logic [NB_SW-1:0]  o_sw_change
);

    localparam int                     c_nb_all   = NB_BTN + NB_SW;
    localparam logic [NB_DEBOUNCE-1:0] c_cnt_last = NB_DEBOUNCE'(DEBOUNCE_COUNT - 1);

    logic [c_nb_all-1:0] w_raw;

    // Buttons occupy the low bits, switches the high bits.
    assign w_raw = {i_sw, i_btn};

    genvar gi;
    generate
        for (gi = 0; gi < c_nb_all; gi++) begin : g_bit
            logic                   r_s1;
            logic                   r_s2;
            logic                   r_stable;
            logic [NB_DEBOUNCE-1:0] r_cnt;
            logic                   w_differ;
            logic                   w_accept;

            assign w_differ = r_s2 ^ r_stable;
            assign w_accept = w_differ && (r_cnt == c_cnt_last);

            always_ff @(posedge clock) begin
                if (reset) begin
                    r_s1     <= 1'b0;
                    r_s2     <= 1'b0;
                    r_stable <= 1'b0;
                    r_cnt    <= '0;
                end else begin
                    r_s1 <= w_raw[gi];
                    r_s2 <= r_s1;
                    // Any return to the stable value restarts the count.
                    if (!w_differ || w_accept) begin
                        r_cnt <= '0;
                    end else begin
                        r_cnt <= r_cnt + 1'b1;
                    end
                    if (w_accept) begin
                        r_stable <= r_s2;
                    end
                end
            end

            if (gi < NB_BTN) begin : g_btn_evt
                logic r_press;
                logic r_release;

                always_ff @(posedge clock) begin
                    if (reset) begin
                        r_press   <= 1'b0;
                        r_release <= 1'b0;
                    end else begin
                        r_press   <= w_accept & r_s2;
                        r_release <= w_accept & ~r_s2;
                    end
                end

                assign o_btn_level[gi]   = r_stable;
                assign o_btn_press[gi]   = r_press;
                assign o_btn_release[gi] = r_release;
            end else begin : g_sw_evt
                logic r_change;

                always_ff @(posedge clock) begin
                    if (reset) begin
                        r_change <= 1'b0;
                    end else begin
                        r_change <= w_accept;
                    end
                end

                assign o_sw_level[gi-NB_BTN]  = r_stable;
                assign o_sw_change[gi-NB_BTN] = r_change;
            end
        end
    endgenerate

endmodule
`default_nettype wire

// File: tb/tb_btn_sw_conditioner.sv
`default_nettype none
// ============================================================================
// Module   : tb_btn_sw_conditioner
// Brief    : Directed scoreboard bench for btn_sw_conditioner (count of 4).
// Revision : 1.0 - initial release
// ============================================================================
module tb_btn_sw_conditioner;

    localparam int DC  = 4;
    // Drive at a falling edge, sampled at the next rising edge N, visible at N+DC+1.
    localparam int LAT = DC + 2;

    logic       clock = 1'b0;
    logic       reset = 1'b1;
    logic [3:0] i_btn = 4'b0;
    logic [3:0] i_sw  = 4'b0;
    logic [3:0] o_btn_level;
    logic [3:0] o_btn_press;
    logic [3:0] o_btn_release;
    logic [3:0] o_sw_level;
    logic [3:0] o_sw_change;

    btn_sw_conditioner #(
        .NB_BTN         (4),
        .NB_SW          (4),
        .NB_DEBOUNCE    (3),
        .DEBOUNCE_COUNT (DC)
    ) dut (
        .clock         (clock),
        .reset         (reset),
        .i_btn         (i_btn),
        .i_sw          (i_sw),
        .o_btn_level   (o_btn_level),
        .o_btn_press   (o_btn_press),
        .o_btn_release (o_btn_release),
        .o_sw_level    (o_sw_level),
        .o_sw_change   (o_sw_change)
    );

    always #5 clock = ~clock;

    int cyc = 0;
    always @(posedge clock) cyc <= cyc + 1;

    typedef struct {
        int         at;
        logic [3:0] press;
        logic [3:0] rel;
        logic [3:0] chg;
        logic [3:0] btn_lvl;
        logic [3:0] sw_lvl;
    } evt_t;

    evt_t       q[$];
    evt_t       mon_e;
    int         checks = 0;
    int         errors = 0;
    bit         mon_en = 1'b0;
    logic [3:0] exp_btn_lvl = 4'b0;
    logic [3:0] exp_sw_lvl  = 4'b0;

    // Monitor: any pulse (or a due event) consumes one scoreboard entry.
    always @(negedge clock) begin
        if (mon_en) begin
            if ((|{o_btn_press, o_btn_release, o_sw_change}) ||
                (q.size() > 0 && q[0].at <= cyc)) begin
                checks++;
                if (q.size() == 0) begin
                    errors++;
                    $display("FAIL unexpected_pulse cyc=%0d press=%b rel=%b chg=%b want none",
                             cyc, o_btn_press, o_btn_release, o_sw_change);
                end else begin
                    mon_e = q.pop_front();
                    if (mon_e.at != cyc || o_btn_press !== mon_e.press ||
                        o_btn_release !== mon_e.rel || o_sw_change !== mon_e.chg) begin
                        errors++;
                        $display("FAIL event cyc=%0d want_cyc=%0d press=%b/%b rel=%b/%b chg=%b/%b (got/want)",
                                 cyc, mon_e.at, o_btn_press, mon_e.press,
                                 o_btn_release, mon_e.rel, o_sw_change, mon_e.chg);
                    end
                    exp_btn_lvl = mon_e.btn_lvl;
                    exp_sw_lvl  = mon_e.sw_lvl;
                end
            end
            checks++;
            if (o_btn_level !== exp_btn_lvl || o_sw_level !== exp_sw_lvl) begin
                errors++;
                $display("FAIL level cyc=%0d btn=%b want %b sw=%b want %b",
                         cyc, o_btn_level, exp_btn_lvl, o_sw_level, exp_sw_lvl);
            end
        end
    end

    task automatic tick(input int n);
        repeat (n) @(negedge clock);
    endtask

    task automatic expect_evt(input int dly, input logic [3:0] p, input logic [3:0] r,
                              input logic [3:0] c, input logic [3:0] bl, input logic [3:0] sl);
        q.push_back('{cyc + dly, p, r, c, bl, sl});
    endtask

    task automatic check_reset(input string name);
        checks++;
        if ({o_btn_level, o_btn_press, o_btn_release, o_sw_level, o_sw_change} !== 20'h0) begin
            errors++;
            $display("FAIL %s outputs=%h want 00000", name,
                     {o_btn_level, o_btn_press, o_btn_release, o_sw_level, o_sw_change});
        end
    endtask

    initial begin
        tick(3);
        check_reset("reset_state");
        reset  = 1'b0;
        mon_en = 1'b1;
        tick(20);

        // Single press, then release.
        i_btn[0] = 1'b1;
        expect_evt(LAT, 4'b0001, 4'b0000, 4'b0000, 4'b0001, 4'b0000);
        tick(10);
        i_btn[0] = 1'b0;
        expect_evt(LAT, 4'b0000, 4'b0001, 4'b0000, 4'b0000, 4'b0000);
        tick(10);

        // Three-cycle glitch rejected; four-cycle pulse accepted.
        i_btn[1] = 1'b1;
        tick(3);
        i_btn[1] = 1'b0;
        tick(10);
        i_btn[1] = 1'b1;
        expect_evt(LAT, 4'b0010, 4'b0000, 4'b0000, 4'b0010, 4'b0000);
        tick(4);
        i_btn[1] = 1'b0;
        expect_evt(LAT, 4'b0000, 4'b0010, 4'b0000, 4'b0000, 4'b0000);
        tick(12);

        // Bounce then hold.
        for (int i = 0; i < 10; i++) begin
            i_btn[2] = ~i[0];
            tick(1);
        end
        i_btn[2] = 1'b1;
        expect_evt(LAT, 4'b0100, 4'b0000, 4'b0000, 4'b0100, 4'b0000);
        tick(10);

        // Switches together, then simultaneous buttons.
        i_sw = 4'b1010;
        expect_evt(LAT, 4'b0000, 4'b0000, 4'b1010, 4'b0100, 4'b1010);
        tick(10);
        i_btn[2] = 1'b0;
        expect_evt(LAT, 4'b0000, 4'b0100, 4'b0000, 4'b0000, 4'b1010);
        tick(10);
        i_btn = 4'b1110;
        expect_evt(LAT, 4'b1110, 4'b0000, 4'b0000, 4'b1110, 4'b1010);
        tick(10);
        i_btn = 4'b0000;
        i_sw  = 4'b0000;
        expect_evt(LAT, 4'b0000, 4'b1110, 4'b1010, 4'b0000, 4'b0000);
        tick(10);

        // Reset mid-debounce with the button held.
        i_btn[0] = 1'b1;
        tick(3);
        reset = 1'b1;
        tick(1);
        check_reset("mid_reset_a");
        tick(2);
        check_reset("mid_reset_b");
        reset = 1'b0;
        expect_evt(LAT, 4'b0001, 4'b0000, 4'b0000, 4'b0001, 4'b0000);
        tick(10);
        i_btn[0] = 1'b0;
        expect_evt(LAT, 4'b0000, 4'b0001, 4'b0000, 4'b0000, 4'b0000);
        tick(10);

        checks++;
        if (q.size() != 0) begin
            errors++;
            $display("FAIL pending_events left=%0d want 0", q.size());
        end
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
`default_nettype wire
